// File: rtl/up_down_counter.sv
// Enable-gated up/down counter wrapping modulo 2**WIDTH (WIDTH legal range 1..32).
// Define UP_DOWN_COUNTER_STATUS_EN to add the at_max/at_min flags and the registered wrap pulse.
module up_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
`ifdef UP_DOWN_COUNTER_STATUS_EN
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_next;

    // up_down is only looked at under en, so an unknown direction cannot leak into a held count.
    always_comb begin
        count_next = count;
        if (en) begin
            if (up_down) count_next = count + 1'b1;
            else         count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else       count <= count_next;
    end

`ifdef UP_DOWN_COUNTER_STATUS_EN
    logic wrap_next;

    assign at_max = (count == {WIDTH{1'b1}});
    assign at_min = (count == {WIDTH{1'b0}});

    // A wrap is an enabled step taken from the terminal value in the direction of travel.
    always_comb begin
        wrap_next = 1'b0;
        if (en) wrap_next = up_down ? at_max : at_min;
    end

    always_ff @(posedge clk) begin
        if (reset) wrap <= 1'b0;
        else       wrap <= wrap_next;
    end
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter (WIDTH = 4); the status checks are included when
// UP_DOWN_COUNTER_STATUS_EN is defined.
module tb_up_down_counter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic         up_down;
    logic [W-1:0] count;
`ifdef UP_DOWN_COUNTER_STATUS_EN
    logic         at_max;
    logic         at_min;
    logic         wrap;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    up_down_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up_down (up_down),
`ifdef UP_DOWN_COUNTER_STATUS_EN
        .at_max  (at_max),
        .at_min  (at_min),
        .wrap    (wrap),
`endif
        .count   (count)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // scoreboard: pop the expected count and compare, plus status flags when present
    task automatic check(input string tag, input logic exp_wrap);
        logic [W-1:0] exp_count;
        exp_count = exp_q.pop_front();
        checks++;
        assert (count === exp_count) else begin
            errors++;
            $error("FAIL %s count: observed %0d expected %0d", tag, count, exp_count);
        end
`ifdef UP_DOWN_COUNTER_STATUS_EN
        checks++;
        assert (wrap === exp_wrap) else begin
            errors++;
            $error("FAIL %s wrap: observed %b expected %b", tag, wrap, exp_wrap);
        end
        checks++;
        assert (at_max === (exp_count == 4'd15)) else begin
            errors++;
            $error("FAIL %s at_max: observed %b expected %b", tag, at_max, (exp_count == 4'd15));
        end
        checks++;
        assert (at_min === (exp_count == 4'd0)) else begin
            errors++;
            $error("FAIL %s at_min: observed %b expected %b", tag, at_min, (exp_count == 4'd0));
        end
`else
        if (exp_wrap) begin end
`endif
    endtask

    // driver: apply inputs away from the edge, take one edge, sample 1 time unit later
    task automatic step(input string tag, input logic r, input logic e, input logic ud,
                        input logic [W-1:0] exp_count, input logic exp_wrap);
        @(negedge clk);
        reset   = r;
        en      = e;
        up_down = ud;
        exp_q.push_back(exp_count);
        @(posedge clk);
        #1;
        check(tag, exp_wrap);
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        up_down = 1'b0;

        // reset for two edges
        step("reset0", 1, 0, 0, 4'd0, 0);
        step("reset1", 1, 0, 1, 4'd0, 0);

        // count up 10 steps from 0
        for (int i = 1; i <= 10; i++) step("up", 0, 1, 1, W'(i), 0);

        // bring to 14, then up across the wrap
        for (int i = 11; i <= 14; i++) step("up_to14", 0, 1, 1, W'(i), 0);
        step("up_15",      0, 1, 1, 4'd15, 0);
        step("up_wrap_0",  0, 1, 1, 4'd0,  1);
        step("up_1",       0, 1, 1, 4'd1,  0);

        // up to 2, then down across the wrap (direction change is immediate)
        step("up_2",        0, 1, 1, 4'd2,  0);
        step("down_1",      0, 1, 0, 4'd1,  0);
        step("down_0",      0, 1, 0, 4'd0,  0);
        step("down_wrap15", 0, 1, 0, 4'd15, 1);
        step("down_14",     0, 1, 0, 4'd14, 0);

        // down to 7
        for (int i = 13; i >= 7; i--) step("down_to7", 0, 1, 0, W'(i), 0);

        // hold at 7 with up_down toggling
        for (int i = 0; i < 5; i++) step("hold", 0, 0, i[0], 4'd7, 0);

        // hold with an unknown direction must not disturb the count
        step("hold_x", 0, 0, 1'bx, 4'd7, 0);

        // up to 9, then reset mid-count with en high
        step("up_8",     0, 1, 1, 4'd8, 0);
        step("up_9",     0, 1, 1, 4'd9, 0);
        step("mid_rst",  1, 1, 1, 4'd0, 0);
        step("resume_1", 0, 1, 1, 4'd1, 0);

        // wrap pulse is cleared by a hold cycle right after a wrap
        step("down_0b",    0, 1, 0, 4'd0,  0);
        step("wrap_again", 0, 1, 0, 4'd15, 1);
        step("hold_clr",   0, 0, 0, 4'd15, 0);

        // wrap pulse is cleared by reset right after a wrap
        step("wrap_up",    0, 1, 1, 4'd0,  1);
        step("down_15",    0, 1, 0, 4'd15, 1);
        step("rst_clr",    1, 1, 0, 4'd0,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
